// File: rtl/button_event_unit_pkg.sv
// Shared definitions for the button event unit: event encodings and width helpers,
// also used by the bus-side register decoder.
package button_event_unit_pkg;

   localparam logic EVT_RISE = 1'b1;
   localparam logic EVT_FALL = 1'b0;

   // Ceiling log2; clog2(1) == 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

   // Line-index field width; at least one bit even for a single line.
   function automatic int unsigned idx_width(input int unsigned width);
      return (width > 1) ? clog2(width) : 1;
   endfunction

   // Occupancy counter width; must represent 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/button_event_unit_if.sv
// CPU-side event pop port and status of the button event unit.
interface button_event_unit_if
   import button_event_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned IDXW = idx_width(WIDTH);
   localparam int unsigned CNTW = cnt_width(DEPTH);

   logic            evt_valid;
   logic            evt_ready;
   logic [IDXW:0]   evt_data;
   logic [CNTW-1:0] evt_count;
   logic            irq;
   logic            overflow;
   logic            overflow_clr;

   modport master (
      output evt_valid, evt_data, evt_count, irq, overflow,
      input  evt_ready, overflow_clr
   );

   modport slave (
      input  evt_valid, evt_data, evt_count, irq, overflow,
      output evt_ready, overflow_clr
   );

endinterface

// File: rtl/button_event_unit_sync_fifo.sv
// First-word-fall-through event FIFO with registered valid/full/count.
module button_event_unit_sync_fifo
   import button_event_unit_pkg::*;
#(
   parameter int unsigned WIDTH_D = 3,
   parameter int unsigned DEPTH   = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH_D-1:0]        push_data,
   input  logic                      pop,
   output logic [WIDTH_D-1:0]        rd_data,
   output logic                      valid,
   output logic                      full,
   output logic [cnt_width(DEPTH)-1:0] count
);
   localparam int unsigned PTRW = clog2(DEPTH);
   localparam int unsigned CNTW = cnt_width(DEPTH);

   logic [WIDTH_D-1:0] mem [DEPTH];
   logic [PTRW-1:0]    wr_ptr;
   logic [PTRW-1:0]    rd_ptr;
   logic [CNTW-1:0]    count_n;
   logic               do_push;
   logic               do_pop;

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop && valid;
      do_push = push && (!full || do_pop);
      count_n = count;
      case ({do_push, do_pop})
         2'b10:   count_n = count + CNTW'(1);
         2'b01:   count_n = count - CNTW'(1);
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
         count <= count_n;
         valid <= (count_n != '0);
         full  <= (count_n == CNTW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/button_event_unit.sv
// Turns debounced line levels into queued rise/fall events with interrupt and
// sticky lost-edge flag.
module button_event_unit
   import button_event_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] debounced_in,
   button_event_unit_if.master bus
);
   localparam int unsigned IDXW = idx_width(WIDTH);
   localparam int unsigned DW   = IDXW + 1;

   logic             armed;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise_pend;
   logic [WIDTH-1:0] fall_pend;
   logic             overflow_q;

   logic [WIDTH-1:0] rise_det;
   logic [WIDTH-1:0] fall_det;
   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] clr_rise;
   logic [WIDTH-1:0] clr_fall;
   logic [IDXW-1:0]  sel_idx;
   logic             sel_rise;
   logic             found;
   logic             push;
   logic             pop;
   logic             full;
   logic             merge;
   logic [DW-1:0]    push_data;

   // Edge detection is suppressed on the arming cycle so lines high out of reset stay silent.
   always_comb begin
      rise_det = armed ? (debounced_in & ~prev) : '0;
      fall_det = armed ? (~debounced_in & prev) : '0;
   end

   // Lowest pending line wins; with both polarities pending the older edge is opposite to prev.
   always_comb begin
      found    = 1'b0;
      sel      = '0;
      sel_idx  = '0;
      sel_rise = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!found && (rise_pend[i] || fall_pend[i])) begin
            found    = 1'b1;
            sel[i]   = 1'b1;
            sel_idx  = IDXW'(i);
            sel_rise = rise_pend[i] && !(fall_pend[i] && prev[i]);
         end
      end
   end

   always_comb begin
      pop       = bus.evt_valid && bus.evt_ready;
      push      = found && (!full || pop);
      clr_rise  = (push && sel_rise)  ? sel : '0;
      clr_fall  = (push && !sel_rise) ? sel : '0;
      push_data = {(sel_rise ? EVT_RISE : EVT_FALL), sel_idx};
      merge     = (|(rise_det & rise_pend & ~clr_rise)) ||
                  (|(fall_det & fall_pend & ~clr_fall));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         armed      <= 1'b0;
         prev       <= '0;
         rise_pend  <= '0;
         fall_pend  <= '0;
         overflow_q <= 1'b0;
      end else begin
         armed     <= 1'b1;
         prev      <= debounced_in;
         rise_pend <= (rise_pend & ~clr_rise) | rise_det;
         fall_pend <= (fall_pend & ~clr_fall) | fall_det;
         if (merge)                 overflow_q <= 1'b1;
         else if (bus.overflow_clr) overflow_q <= 1'b0;
      end
   end

   button_event_unit_sync_fifo #(
      .WIDTH_D (DW),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .rd_data   (bus.evt_data),
      .valid     (bus.evt_valid),
      .full      (full),
      .count     (bus.evt_count)
   );

   assign bus.irq      = bus.evt_valid;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_button_event_unit.sv
// Bench for button_event_unit: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_button_event_unit;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] din = '0;
   int         checks = 0;
   int         failures = 0;

   button_event_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   button_event_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .debounced_in (din),
      .bus          (bus.master)
   );

   always #5 clk = ~clk;

   // Reference model: pending edges per line and the event queue as an SV queue.
   bit         m_armed;
   bit [3:0]   m_prev;
   bit [3:0]   m_rp;
   bit [3:0]   m_fp;
   bit         m_ovf;
   logic [2:0] m_q[$];

   function automatic void model_clock(input logic rst_i, input logic [3:0] in,
                                       input logic rdy, input logic clr);
      bit do_pop;
      bit merged;
      bit older_rise;
      int sel;
      if (rst_i) begin
         m_armed = 0; m_prev = '0; m_rp = '0; m_fp = '0; m_ovf = 0;
         m_q.delete();
         return;
      end
      do_pop = (m_q.size() != 0) && rdy;
      sel = -1;
      for (int i = 0; i < 4; i++)
         if (sel < 0 && (m_rp[i] || m_fp[i])) sel = i;
      if (do_pop) void'(m_q.pop_front());
      if (sel >= 0 && m_q.size() < DEPTH) begin
         older_rise = m_rp[sel] && !(m_fp[sel] && m_prev[sel]);
         m_q.push_back({older_rise, 2'(sel)});
         if (older_rise) m_rp[sel] = 0; else m_fp[sel] = 0;
      end
      merged = 0;
      if (m_armed) begin
         for (int i = 0; i < 4; i++) begin
            if (in[i] && !m_prev[i]) begin
               if (m_rp[i]) merged = 1;
               m_rp[i] = 1;
            end
            if (!in[i] && m_prev[i]) begin
               if (m_fp[i]) merged = 1;
               m_fp[i] = 1;
            end
         end
      end
      if (merged) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_prev  = in;
      m_armed = 1;
   endfunction

   task automatic step(input logic [3:0] in, input logic rdy, input logic clr);
      din = in;
      bus.evt_ready = rdy;
      bus.overflow_clr = clr;
      model_clock(reset, in, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      reset = 1'b0;
      checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.evt_valid); end
      checks++; if (bus.evt_data !== 3'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.evt_data); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
      repeat (5) step(4'b0010, 1'b0, 1'b0);
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL arm_count got=%0d exp=0", bus.evt_count); end
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL arm_irq got=%0b exp=0", bus.irq); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL arm_overflow got=%0b exp=0", bus.overflow); end
   endtask

   task automatic test_single_edge();
      step(4'b0011, 1'b0, 1'b0);
      checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%0b exp=0", bus.evt_valid); end
      step(4'b0011, 1'b0, 1'b0);
      checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%0b exp=1", bus.evt_valid); end
      checks++; if (bus.evt_data !== 3'b100) begin failures++; $display("FAIL lat_data got=%0b exp=100", bus.evt_data); end
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL lat_irq got=%0b exp=1", bus.irq); end
      step(4'b0011, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL pop_count got=%0d exp=0", bus.evt_count); end
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL pop_irq got=%0b exp=0", bus.irq); end
   endtask

   task automatic test_multi_line();
      repeat (5) step(4'b0000, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL multi_drain got=%0d exp=0", bus.evt_count); end
      step(4'b1010, 1'b0, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
      checks++; if (bus.evt_data !== 3'b101) begin failures++; $display("FAIL multi_first got=%0b exp=101", bus.evt_data); end
      step(4'b1010, 1'b0, 1'b0);
      checks++; if (bus.evt_count !== 4'd2) begin failures++; $display("FAIL multi_count got=%0d exp=2", bus.evt_count); end
      step(4'b1010, 1'b1, 1'b0);
      checks++; if (bus.evt_data !== 3'b111) begin failures++; $display("FAIL multi_second got=%0b exp=111", bus.evt_data); end
      step(4'b1010, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL multi_empty got=%0d exp=0", bus.evt_count); end
   endtask

   task automatic test_full_stall();
      repeat (8) step(din ^ 4'b0001, 1'b0, 1'b0);
      step(din, 1'b0, 1'b0);
      checks++; if (bus.evt_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", bus.evt_count); end
      step(4'b1110, 1'b0, 1'b0);
      step(4'b1110, 1'b0, 1'b0);
      checks++; if (bus.evt_count !== 4'd8) begin failures++; $display("FAIL stall_count got=%0d exp=8", bus.evt_count); end
      step(4'b1110, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd8) begin failures++; $display("FAIL pushpop_count got=%0d exp=8", bus.evt_count); end
      checks++; if (bus.evt_data !== 3'b000) begin failures++; $display("FAIL pushpop_head got=%0b exp=000", bus.evt_data); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL stall_overflow got=%0b exp=0", bus.overflow); end
      repeat (7) step(4'b1110, 1'b1, 1'b0);
      checks++; if (bus.evt_data !== 3'b110) begin failures++; $display("FAIL stall_tail got=%0b exp=110", bus.evt_data); end
      step(4'b1110, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL stall_empty got=%0d exp=0", bus.evt_count); end
   endtask

   task automatic test_overflow();
      repeat (8) step(din ^ 4'b0001, 1'b0, 1'b0);
      step(din, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1110, 1'b0, 1'b0);
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", bus.overflow); end
      step(4'b1111, 1'b0, 1'b0);
      checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_merge got=%0b exp=1", bus.overflow); end
      repeat (8) step(4'b1111, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd2) begin failures++; $display("FAIL ovf_left got=%0d exp=2", bus.evt_count); end
      checks++; if (bus.evt_data !== 3'b000) begin failures++; $display("FAIL ovf_fall_first got=%0b exp=000", bus.evt_data); end
      step(4'b1111, 1'b1, 1'b0);
      checks++; if (bus.evt_data !== 3'b100) begin failures++; $display("FAIL ovf_rise_next got=%0b exp=100", bus.evt_data); end
      step(4'b1111, 1'b1, 1'b0);
      checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", bus.overflow); end
      step(4'b1111, 1'b0, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", bus.overflow); end
      step(4'b0000, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b1);
      checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%0b exp=1", bus.overflow); end
      step(4'b0000, 1'b1, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear2 got=%0b exp=0", bus.overflow); end
      repeat (8) step(4'b0000, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL ovf_drain got=%0d exp=0", bus.evt_count); end
   endtask

   task automatic test_reset_mid();
      repeat (6) step(din ^ 4'b0001, 1'b0, 1'b0);
      checks++; if (bus.evt_count !== 4'd5) begin failures++; $display("FAIL mid_count got=%0d exp=5", bus.evt_count); end
      reset = 1'b1;
      step(4'b0101, 1'b0, 1'b0);
      reset = 1'b0;
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", bus.evt_count); end
      checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b exp=0", bus.evt_valid); end
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%0b exp=0", bus.irq); end
      repeat (4) step(4'b0101, 1'b1, 1'b0);
      checks++; if (bus.evt_count !== 4'd0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", bus.evt_count); end
   endtask

   task automatic test_random();
      logic [3:0] in;
      logic       rdy;
      logic       clr;
      logic [2:0] exp_data;
      reset = 1'b1;
      step(4'b0000, 1'b0, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 800; k++) begin
         in  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : din;
         rdy = ($urandom_range(0, 99) < ((k % 200) < 100 ? 15 : 75));
         clr = ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 299) == 0);
         step(in, rdy, clr);
         reset = 1'b0;
         exp_data = (m_q.size() != 0) ? m_q[0] : 3'd0;
         checks++; if (bus.evt_count !== 4'(m_q.size())) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", k, bus.evt_count, m_q.size()); end
         checks++; if (bus.evt_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b", k, bus.evt_valid); end
         checks++; if (bus.evt_data !== exp_data) begin failures++; $display("FAIL rand_data cyc=%0d got=%0b exp=%0b", k, bus.evt_data, exp_data); end
         checks++; if (bus.irq !== (m_q.size() != 0)) begin failures++; $display("FAIL rand_irq cyc=%0d got=%0b", k, bus.irq); end
         checks++; if (bus.overflow !== m_ovf) begin failures++; $display("FAIL rand_overflow cyc=%0d got=%0b exp=%0b", k, bus.overflow, m_ovf); end
      end
   endtask

   initial begin
      bus.evt_ready = 1'b0;
      bus.overflow_clr = 1'b0;
      test_reset();
      test_single_edge();
      test_multi_line();
      test_full_stall();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
